// File: rtl/atm_pin_entry_if.sv
// Keypad, card and account-PIN bundle between the ATM front panel and the PIN checker.
// Latency: none, plain wires.
// Backpressure: none; keypad strobes are single-cycle and are never stalled.
interface atm_pin_entry_if #(
    parameter int PIN_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int MAX_TRIES  = 3
);
    localparam int PIN_W = PIN_DIGITS * DIGIT_W;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);

    // front panel / account side
    logic               cardIn;
    logic               key_valid;
    logic [DIGIT_W-1:0] key_digit;
    logic               key_clear;
    logic               key_enter;
    logic [PIN_W-1:0]   stored_pin;

    // PIN checker status towards the ATM core
    logic               pin_ok;
    logic               pin_fail;
    logic               pin_granted;
    logic               card_retained;
    logic [TRY_W-1:0]   tries_left;
    logic [CNT_W-1:0]   digit_count;
    logic               timeout;

    // Panel side: drives card/keys/PIN, observes the verdict.
    modport master (
        output cardIn, key_valid, key_digit, key_clear, key_enter, stored_pin,
        input  pin_ok, pin_fail, pin_granted, card_retained, tries_left,
               digit_count, timeout
    );

    // PIN checker side.
    modport slave (
        input  cardIn, key_valid, key_digit, key_clear, key_enter, stored_pin,
        output pin_ok, pin_fail, pin_granted, card_retained, tries_left,
               digit_count, timeout
    );
endinterface

// File: rtl/atm_pin_entry.sv
// PIN entry and verification: collects keypad digits, checks them, counts failures, retains card.
// Latency: key_enter to pin_ok/pin_fail is 2 cycles; all status outputs are registered.
// Backpressure: none; invalid or excess strobes are dropped. Optional macro ATM_PIN_TIMEOUT_EN adds an idle timeout.
module atm_pin_entry #(
    parameter int PIN_DIGITS  = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic           clk,
    input  logic           reset,
    atm_pin_entry_if.slave bus
);
    localparam int PIN_W = PIN_DIGITS * DIGIT_W;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_COLLECT  = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_GRANTED  = 3'd3;
    localparam logic [2:0] S_RETAINED = 3'd4;

    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(PIN_DIGITS);
    localparam logic [TRY_W-1:0]   TRIES_MAX = TRY_W'(MAX_TRIES);
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [PIN_W-1:0] entry_buf;
    logic [CNT_W-1:0] digit_cnt;
    logic [TRY_W-1:0] tries;
    logic             pin_ok_q;
    logic             pin_fail_q;
    logic             granted_q;
    logic             retained_q;
    logic             timeout_q;

    logic             in_collect;
    logic             digit_ok;
    logic             do_clear;
    logic             do_digit;
    logic             do_enter;
    logic             pin_match;
    logic             last_try;
    logic             timeout_hit;

    // Keypad decode: a strobe only acts in COLLECT with the card present,
    // and only the highest-priority asserted strobe is considered.
    always_comb begin
        in_collect = (state == S_COLLECT) && bus.cardIn;
        digit_ok   = (digit_cnt != FULL_CNT) && (bus.key_digit <= DIGIT_MAX);
        do_clear   = in_collect && bus.key_clear;
        do_digit   = in_collect && !bus.key_clear && bus.key_valid && digit_ok;
        do_enter   = in_collect && !bus.key_clear && !bus.key_valid && bus.key_enter;
        pin_match  = (digit_cnt == FULL_CNT) && (entry_buf == bus.stored_pin);
        last_try   = (tries <= TRY_W'(1));
    end

`ifdef ATM_PIN_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [IDLE_W-1:0] idle_cnt;
    logic              strobe_accepted;

    // A rejected digit (overflow or non-BCD) does not count as activity.
    assign strobe_accepted = do_clear || do_digit || do_enter;
    assign timeout_hit     = in_collect && !strobe_accepted &&
                             (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    // Idle cycle counter; parked at zero outside COLLECT so every entry starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (!in_collect || strobe_accepted || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Session state transitions; card removal wins over everything but retention.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.cardIn && !retained_q) begin
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (!bus.cardIn) begin
                    state_nxt = S_IDLE;
                end else if (do_enter) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!bus.cardIn) begin
                    state_nxt = S_IDLE;
                end else if (pin_match) begin
                    state_nxt = S_GRANTED;
                end else if (last_try) begin
                    state_nxt = S_RETAINED;
                end else begin
                    state_nxt = S_COLLECT;
                end
            end
            S_GRANTED: begin
                if (!bus.cardIn) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RETAINED: begin
                state_nxt = S_RETAINED;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register, entry buffer, attempt counter and registered verdict pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            entry_buf  <= '0;
            digit_cnt  <= '0;
            tries      <= TRIES_MAX;
            pin_ok_q   <= 1'b0;
            pin_fail_q <= 1'b0;
            granted_q  <= 1'b0;
            retained_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            pin_ok_q   <= 1'b0;
            pin_fail_q <= 1'b0;
            timeout_q  <= timeout_hit;
            case (state)
                S_IDLE: begin
                    // A new session always starts with a full set of attempts.
                    if (bus.cardIn && !retained_q) begin
                        entry_buf <= '0;
                        digit_cnt <= '0;
                        tries     <= TRIES_MAX;
                    end
                end
                S_COLLECT: begin
                    if (!bus.cardIn || do_clear || timeout_hit) begin
                        entry_buf <= '0;
                        digit_cnt <= '0;
                    end else if (do_digit) begin
                        // First digit typed ends up in the MSBs after PIN_DIGITS shifts.
                        entry_buf <= {entry_buf[PIN_W-DIGIT_W-1:0], bus.key_digit};
                        digit_cnt <= digit_cnt + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (!bus.cardIn) begin
                        // Aborted session: no verdict, nothing consumed.
                        entry_buf <= '0;
                        digit_cnt <= '0;
                    end else if (pin_match) begin
                        pin_ok_q  <= 1'b1;
                        granted_q <= 1'b1;
                    end else begin
                        pin_fail_q <= 1'b1;
                        entry_buf  <= '0;
                        digit_cnt  <= '0;
                        if (tries != '0) begin
                            tries <= tries - TRY_W'(1);
                        end
                        if (last_try) begin
                            retained_q <= 1'b1;
                        end
                    end
                end
                S_GRANTED: begin
                    // Do not leave the accepted PIN lying in the buffer after the session.
                    if (!bus.cardIn) begin
                        granted_q <= 1'b0;
                        entry_buf <= '0;
                        digit_cnt <= '0;
                    end
                end
                default: begin
                    // RETAINED: frozen until reset.
                end
            endcase
        end
    end

    assign bus.pin_ok        = pin_ok_q;
    assign bus.pin_fail      = pin_fail_q;
    assign bus.pin_granted   = granted_q;
    assign bus.card_retained = retained_q;
    assign bus.tries_left    = tries;
    assign bus.digit_count   = digit_cnt;
    assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Directed bench for atm_pin_entry: cycle-by-cycle vector table plus hand-written reset/timeout sequences.
// Latency: expected values are the register contents just after each sampled clock edge.
// Backpressure: not applicable; the bench drives one strobe per cycle.
module tb_atm_pin_entry;
    localparam int PIN_DIGITS  = 4;
    localparam int DIGIT_W     = 4;
    localparam int MAX_TRIES   = 3;
    localparam int TIMEOUT_CYC = 20;

    logic Clock_tb;
    logic reset;

    atm_pin_entry_if #(
        .PIN_DIGITS (PIN_DIGITS),
        .DIGIT_W    (DIGIT_W),
        .MAX_TRIES  (MAX_TRIES)
    ) bus ();

    atm_pin_entry #(
        .PIN_DIGITS  (PIN_DIGITS),
        .DIGIT_W     (DIGIT_W),
        .MAX_TRIES   (MAX_TRIES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk   (Clock_tb),
        .reset (reset),
        .bus   (bus)
    );

    initial Clock_tb = 1'b0;
    always #5 Clock_tb = ~Clock_tb;

    typedef struct {
        string      nm;
        logic       card;
        logic       kv;
        logic [3:0] dig;
        logic       kc;
        logic       ke;
        logic       ok;
        logic       fail;
        logic       gr;
        logic       ret;
        int         tl;
        int         dc;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(string nm, logic card, logic kv, logic [3:0] dig,
                                logic kc, logic ke, logic ok, logic fail, logic gr,
                                logic ret, int tl, int dc);
        vec_t v;
        v.nm = nm; v.card = card; v.kv = kv; v.dig = dig; v.kc = kc; v.ke = ke;
        v.ok = ok; v.fail = fail; v.gr = gr; v.ret = ret; v.tl = tl; v.dc = dc;
        tbl.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock_tb);
        #1;
    endtask

    task automatic idle_inputs();
        bus.key_valid = 1'b0;
        bus.key_digit = '0;
        bus.key_clear = 1'b0;
        bus.key_enter = 1'b0;
    endtask

    task automatic chk_reset_values(string tag);
        chk({tag, "_pin_ok"},      32'(bus.pin_ok),        0);
        chk({tag, "_pin_fail"},    32'(bus.pin_fail),      0);
        chk({tag, "_granted"},     32'(bus.pin_granted),   0);
        chk({tag, "_retained"},    32'(bus.card_retained), 0);
        chk({tag, "_tries_left"},  32'(bus.tries_left),    MAX_TRIES);
        chk({tag, "_digit_count"}, 32'(bus.digit_count),   0);
        chk({tag, "_timeout"},     32'(bus.timeout),       0);
    endtask

    initial begin
        // name                  card kv dig kc ke   ok fl gr rt tl dc
        // correct PIN, then keys ignored while granted
        add("s1_insert",          1, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0);
        add("s1_d1",              1, 1, 1, 0, 0,    0, 0, 0, 0, 3, 1);
        add("s1_d2",              1, 1, 2, 0, 0,    0, 0, 0, 0, 3, 2);
        add("s1_d3",              1, 1, 3, 0, 0,    0, 0, 0, 0, 3, 3);
        add("s1_d4",              1, 1, 4, 0, 0,    0, 0, 0, 0, 3, 4);
        add("s1_enter",           1, 0, 0, 0, 1,    0, 0, 0, 0, 3, 4);
        add("s1_pin_ok",          1, 0, 0, 0, 0,    1, 0, 1, 0, 3, 4);
        add("s1_granted",         1, 0, 0, 0, 0,    0, 0, 1, 0, 3, 4);
        add("s1_key_ignored",     1, 1, 5, 0, 0,    0, 0, 1, 0, 3, 4);
        add("s1_enter_ignored",   1, 0, 0, 0, 1,    0, 0, 1, 0, 3, 4);
        add("s1_pull",            0, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0);
        // short entry fails, then clear (beats a same-cycle digit) and correct PIN
        add("s2_insert",          1, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0);
        add("s2_d1",              1, 1, 1, 0, 0,    0, 0, 0, 0, 3, 1);
        add("s2_d2",              1, 1, 2, 0, 0,    0, 0, 0, 0, 3, 2);
        add("s2_enter",           1, 0, 0, 0, 1,    0, 0, 0, 0, 3, 2);
        add("s2_fail",            1, 0, 0, 0, 0,    0, 1, 0, 0, 2, 0);
        add("s2_d9a",             1, 1, 9, 0, 0,    0, 0, 0, 0, 2, 1);
        add("s2_d9b",             1, 1, 9, 0, 0,    0, 0, 0, 0, 2, 2);
        add("s2_clear_over_key",  1, 1, 3, 1, 0,    0, 0, 0, 0, 2, 0);
        add("s2_d1",              1, 1, 1, 0, 0,    0, 0, 0, 0, 2, 1);
        add("s2_d2b",             1, 1, 2, 0, 0,    0, 0, 0, 0, 2, 2);
        add("s2_d3",              1, 1, 3, 0, 0,    0, 0, 0, 0, 2, 3);
        add("s2_d4",              1, 1, 4, 0, 0,    0, 0, 0, 0, 2, 4);
        add("s2_enter2",          1, 0, 0, 0, 1,    0, 0, 0, 0, 2, 4);
        add("s2_pin_ok",          1, 0, 0, 0, 0,    1, 0, 1, 0, 2, 4);
        add("s2_pull",            0, 0, 0, 0, 0,    0, 0, 0, 0, 2, 0);
        // overflow digit and non-BCD digits are dropped; tries restored on new session
        add("s3_insert",          1, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0);
        add("s3_d1",              1, 1, 1, 0, 0,    0, 0, 0, 0, 3, 1);
        add("s3_dA_partial",      1, 1, 4'hA, 0, 0, 0, 0, 0, 0, 3, 1);
        add("s3_d2",              1, 1, 2, 0, 0,    0, 0, 0, 0, 3, 2);
        add("s3_d3",              1, 1, 3, 0, 0,    0, 0, 0, 0, 3, 3);
        add("s3_d4",              1, 1, 4, 0, 0,    0, 0, 0, 0, 3, 4);
        add("s3_d7_overflow",     1, 1, 7, 0, 0,    0, 0, 0, 0, 3, 4);
        add("s3_dA_full",         1, 1, 4'hA, 0, 0, 0, 0, 0, 0, 3, 4);
        add("s3_enter",           1, 0, 0, 0, 1,    0, 0, 0, 0, 3, 4);
        add("s3_pin_ok",          1, 0, 0, 0, 0,    1, 0, 1, 0, 3, 4);
        add("s3_pull",            0, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0);
        // card pulled mid-entry and during CHECK: no pulses, buffer dropped
        add("s4_insert",          1, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0);
        add("s4_d1",              1, 1, 1, 0, 0,    0, 0, 0, 0, 3, 1);
        add("s4_d2",              1, 1, 2, 0, 0,    0, 0, 0, 0, 3, 2);
        add("s4_pull_with_key",   0, 1, 3, 0, 0,    0, 0, 0, 0, 3, 0);
        add("s4_idle_out",        0, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0);
        add("s4_insert2",         1, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0);
        add("s4_d1b",             1, 1, 1, 0, 0,    0, 0, 0, 0, 3, 1);
        add("s4_d2b",             1, 1, 2, 0, 0,    0, 0, 0, 0, 3, 2);
        add("s4_d3b",             1, 1, 3, 0, 0,    0, 0, 0, 0, 3, 3);
        add("s4_d4b",             1, 1, 4, 0, 0,    0, 0, 0, 0, 3, 4);
        add("s4_enter",           1, 0, 0, 0, 1,    0, 0, 0, 0, 3, 4);
        add("s4_pull_in_check",   0, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0);
        add("s4_no_late_pulse",   0, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0);
        add("s4_insert3",         1, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0);
        add("s4_d1c",             1, 1, 1, 0, 0,    0, 0, 0, 0, 3, 1);
        add("s4_d2c",             1, 1, 2, 0, 0,    0, 0, 0, 0, 3, 2);
        add("s4_d3c",             1, 1, 3, 0, 0,    0, 0, 0, 0, 3, 3);
        add("s4_d4c",             1, 1, 4, 0, 0,    0, 0, 0, 0, 3, 4);
        add("s4_enter2",          1, 0, 0, 0, 1,    0, 0, 0, 0, 3, 4);
        add("s4_pin_ok",          1, 0, 0, 0, 0,    1, 0, 1, 0, 3, 4);
        add("s4_pull",            0, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0);
        // three wrong PINs retain the card for good
        add("s5_insert",          1, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0);
        for (int a = 0; a < 3; a++) begin
            add("s5_w1",          1, 1, 1, 0, 0,    0, 0, 0, 0, 3 - a, 1);
            add("s5_w2",          1, 1, 2, 0, 0,    0, 0, 0, 0, 3 - a, 2);
            add("s5_w3",          1, 1, 3, 0, 0,    0, 0, 0, 0, 3 - a, 3);
            add("s5_w5",          1, 1, 5, 0, 0,    0, 0, 0, 0, 3 - a, 4);
            add("s5_enter",       1, 0, 0, 0, 1,    0, 0, 0, 0, 3 - a, 4);
            add("s5_fail",        1, 0, 0, 0, 0,    0, 1, 0, (a == 2), 2 - a, 0);
        end
        add("s5_ret_d1",          1, 1, 1, 0, 0,    0, 0, 0, 1, 0, 0);
        add("s5_ret_d2",          1, 1, 2, 0, 0,    0, 0, 0, 1, 0, 0);
        add("s5_ret_d3",          1, 1, 3, 0, 0,    0, 0, 0, 1, 0, 0);
        add("s5_ret_d4",          1, 1, 4, 0, 0,    0, 0, 0, 1, 0, 0);
        add("s5_ret_enter",       1, 0, 0, 0, 1,    0, 0, 0, 1, 0, 0);
        add("s5_ret_no_ok",       1, 0, 0, 0, 0,    0, 0, 0, 1, 0, 0);
        add("s5_ret_pull",        0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 0);
        add("s5_ret_reinsert",    1, 0, 0, 0, 0,    0, 0, 0, 1, 0, 0);
        add("s5_ret_reinsert2",   1, 0, 0, 0, 0,    0, 0, 0, 1, 0, 0);

        // reset state
        reset          = 1'b1;
        bus.cardIn     = 1'b0;
        bus.stored_pin = 16'h1234;
        idle_inputs();
        step();
        step();
        chk_reset_values("reset");
        reset = 1'b0;
        step();
        chk_reset_values("post_reset_idle");

        // vector table
        foreach (tbl[i]) begin
            bus.cardIn    = tbl[i].card;
            bus.key_valid = tbl[i].kv;
            bus.key_digit = tbl[i].dig;
            bus.key_clear = tbl[i].kc;
            bus.key_enter = tbl[i].ke;
            step();
            chk({tbl[i].nm, "_pin_ok"},      32'(bus.pin_ok),        32'(tbl[i].ok));
            chk({tbl[i].nm, "_pin_fail"},    32'(bus.pin_fail),      32'(tbl[i].fail));
            chk({tbl[i].nm, "_granted"},     32'(bus.pin_granted),   32'(tbl[i].gr));
            chk({tbl[i].nm, "_retained"},    32'(bus.card_retained), 32'(tbl[i].ret));
            chk({tbl[i].nm, "_tries_left"},  32'(bus.tries_left),    32'(tbl[i].tl));
            chk({tbl[i].nm, "_digit_count"}, 32'(bus.digit_count),   32'(tbl[i].dc));
            chk({tbl[i].nm, "_timeout"},     32'(bus.timeout),       0);
        end
        idle_inputs();

        // asynchronous reset releases a retained card without a clock edge
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values("async_reset_retained");
        step();
        reset      = 1'b0;
        bus.cardIn = 1'b0;
        step();

        // idle timeout in COLLECT
        bus.cardIn = 1'b1;
        step();
        bus.key_valid = 1'b1;
        bus.key_digit = 4'd1;
        step();
        idle_inputs();
        chk("to_first_digit", 32'(bus.digit_count), 1);
`ifdef ATM_PIN_TIMEOUT_EN
        for (int i = 1; i < TIMEOUT_CYC; i++) begin
            step();
            chk("to_before_expiry", 32'(bus.timeout), 0);
        end
        chk("to_digits_kept", 32'(bus.digit_count), 1);
        step();
        chk("to_pulse", 32'(bus.timeout), 1);
        chk("to_digits_cleared", 32'(bus.digit_count), 0);
        chk("to_tries_kept", 32'(bus.tries_left), MAX_TRIES);
        chk("to_no_fail", 32'(bus.pin_fail), 0);
        step();
        chk("to_pulse_single", 32'(bus.timeout), 0);
        bus.key_valid = 1'b1;
        bus.key_digit = 4'd8;
        step();
        idle_inputs();
        chk("to_still_collecting", 32'(bus.digit_count), 1);
`else
        for (int i = 0; i < TIMEOUT_CYC + 5; i++) begin
            step();
            chk("no_to_pulse", 32'(bus.timeout), 0);
        end
        chk("no_to_digits_kept", 32'(bus.digit_count), 1);
        chk("no_to_tries_kept", 32'(bus.tries_left), MAX_TRIES);
`endif
        bus.cardIn = 1'b0;
        step();

        // reset asserted mid-entry clears the buffer immediately
        bus.cardIn = 1'b1;
        step();
        bus.key_valid = 1'b1;
        bus.key_digit = 4'd1;
        step();
        bus.key_digit = 4'd2;
        step();
        idle_inputs();
        chk("mid_entry_count", 32'(bus.digit_count), 2);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values("async_reset_mid_entry");
        step();
        reset      = 1'b0;
        bus.cardIn = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
